// File: rtl/frame_scanout_pkg.sv
// Shared definitions for frame_scanout: strobe polarities, FSM encoding and raster totals.
package frame_scanout_pkg;

  // Reset and memory read enable are both active-low.
  localparam logic ASSERT   = 1'b0;
  localparam logic DEASSERT = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_SCAN  = 2'd1,
    RUN_BLANK = 2'd2
  } state_t;

  localparam int DEF_H_ACTIVE = 4;
  localparam int DEF_H_FP     = 1;
  localparam int DEF_H_SYNC   = 2;
  localparam int DEF_H_BP     = 1;
  localparam int DEF_V_ACTIVE = 2;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 1;
  localparam int DEF_V_BP     = 1;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/frame_scanout_timing.sv
// raster_timing: h/v counters (held at zero while !run) and combinational region decode.
module raster_timing
  import frame_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          h_sync,
  output logic          v_sync,
  output logic          fs,
  output logic          fe
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  always_ff @(posedge clk or negedge reset) begin
    if (reset == ASSERT) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (int'(h_cnt) == H_TOT - 1) begin
      h_cnt <= '0;
      v_cnt <= (int'(v_cnt) == V_TOT - 1) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign h_sync = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
  assign v_sync = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
  assign fs     = (h_cnt == '0) && (v_cnt == '0);
  assign fe     = (int'(h_cnt) == H_TOT - 1) && (int'(v_cnt) == V_TOT - 1);

endmodule

// File: rtl/frame_scanout.sv
// Raster scanout: FSM, sequential frame-buffer reads and 2-clk output alignment.
// Optional FRAME_SCANOUT_PATTERN_EN: checkerboard instead of black during RUN_BLANK frames.
module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 3,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  frame_rdy,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_done,
  output logic                  underflow
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  state_t state, state_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic active, h_sync, v_sync, fs, fe;
  logic run, scan_now, rd_go, last_pix;
  logic [ADDR_WIDTH-1:0] ptr, addr_sel;
  logic de1, hs1, vs1, scan1, last1, scan2;
  logic [DATA_WIDTH-1:0] blank_pix;

  assign run = (state != IDLE);

  raster_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .reset(reset), .run(run),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
    .h_sync(h_sync), .v_sync(v_sync), .fs(fs), .fe(fe)
  );

  // The frame's mode is decided by frame_rdy in the FS cycle itself, so the
  // first pixel of the frame already follows the fresh sample.
  assign scan_now = fs ? frame_rdy : (state == RUN_SCAN);
  assign rd_go    = run && active && scan_now;
  assign addr_sel = fs ? '0 : ptr;
  assign last_pix = (int'(h_cnt) == H_ACTIVE - 1) && (int'(v_cnt) == V_ACTIVE - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (reset == ASSERT) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = frame_rdy ? RUN_SCAN : RUN_BLANK;
      default: begin
        if (fe && !en) state_nxt = IDLE;
        else if (fs)   state_nxt = frame_rdy ? RUN_SCAN : RUN_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == ASSERT) begin
      rd_en   <= DEASSERT;
      rd_addr <= '0;
      ptr     <= '0;
      de1     <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      scan1   <= 1'b0;
      last1   <= 1'b0;
    end else begin
      rd_en <= rd_go ? ASSERT : DEASSERT;
      if (rd_go) begin
        rd_addr <= addr_sel;
        ptr     <= addr_sel + 1'b1;
      end else if (run && fs) begin
        rd_addr <= '0;
      end
      de1   <= run && active;
      hs1   <= run && h_sync;
      vs1   <= run && v_sync;
      scan1 <= scan_now;
      last1 <= rd_go && last_pix;
    end
  end

  // Second stage lines up with the memory's registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == ASSERT) begin
      de         <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      scan2      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      de         <= de1;
      hsync      <= hs1;
      vsync      <= vs1;
      scan2      <= scan1;
      frame_done <= last1;
    end
  end

`ifdef FRAME_SCANOUT_PATTERN_EN
  logic pat1, pat2;
  always_ff @(posedge clk or negedge reset) begin
    if (reset == ASSERT) begin
      pat1 <= 1'b0;
      pat2 <= 1'b0;
    end else begin
      pat1 <= h_cnt[0] ^ v_cnt[0];
      pat2 <= pat1;
    end
  end
  assign blank_pix = {DATA_WIDTH{pat2}};
`else
  assign blank_pix = '0;
`endif

  assign pix_data = !de ? '0 : (scan2 ? rd_data : blank_pix);

  always_ff @(posedge clk or negedge reset) begin
    if (reset == ASSERT)                      underflow <= 1'b0;
    else if (run && fs && frame_rdy == 1'b0) underflow <= 1'b1;
  end

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: raster reference model, literal scenario checks, randomized run.
module tb_frame_scanout;
  import frame_scanout_pkg::*;

  localparam int DW = 24, AW = 3;
  localparam int HA = 4, HFP = 1, HS = 2, VA = 2, VFP = 1, VS = 1;
  localparam int HT = 8, VT = 5;

  logic clk = 1'b0, reset = 1'b0, en = 1'b0, frame_rdy = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic rd_en, de, hsync, vsync, frame_done, underflow;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] pix_data;

  always #5 clk = ~clk;

  frame_scanout dut (
    .clk(clk), .reset(reset), .en(en), .frame_rdy(frame_rdy), .rd_data(rd_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .pix_data(pix_data), .de(de),
    .hsync(hsync), .vsync(vsync), .frame_done(frame_done), .underflow(underflow)
  );

  logic [DW-1:0] mem [0:7];
  always @(posedge clk) if (rd_en == 1'b0) rd_data <= mem[rd_addr];

  int tests = 0, fails = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] blank_value(input int h, input int v);
`ifdef FRAME_SCANOUT_PATTERN_EN
    return ((h + v) % 2 == 1) ? {DW{1'b1}} : '0;
`else
    return '0;
`endif
  endfunction

  // Reference model: raster position per clock, outputs derived from the
  // position by arithmetic, then delayed 1 clk (reads) and 2 clks (video).
  typedef struct packed {
    logic rd; logic [AW-1:0] addr; logic de, hs, vs, done; logic [DW-1:0] pix;
  } exp_t;
  exp_t e1, e2, n;
  int m_run, m_h, m_v, m_scan, idx;
  bit m_uf, act, last;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_h = 0; m_v = 0; m_scan = 0; m_uf = 0;
      e1 = '0; e2 = '0;
    end else begin
      n = '0;
      if (m_run == 1 && m_h == 0 && m_v == 0) begin
        m_scan = int'(frame_rdy);
        if (!frame_rdy) m_uf = 1;
      end
      act  = (m_run == 1) && m_h < HA && m_v < VA;
      idx  = m_v * HA + m_h;
      n.de = act;
      n.rd = act && m_scan == 1;
      n.hs = (m_run == 1) && m_h >= HA + HFP && m_h < HA + HFP + HS;
      n.vs = (m_run == 1) && m_v >= VA + VFP && m_v < VA + VFP + VS;
      if (act) begin
        n.addr = AW'(idx);
        n.pix  = (m_scan == 1) ? mem[idx] : blank_value(m_h, m_v);
        n.done = n.rd && idx == HA * VA - 1;
      end
      e2 = e1;
      e1 = n;
      if (m_run == 0) begin
        if (en) m_run = 1;
      end else begin
        last = (m_h == HT - 1) && (m_v == VT - 1);
        m_h  = (m_h + 1) % HT;
        if (m_h == 0) m_v = (m_v + 1) % VT;
        if (last && !en) m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && checking) begin
      check("rd_en", 32'(rd_en), 32'(!e1.rd));
      if (e1.rd) check("rd_addr", 32'(rd_addr), 32'(e1.addr));
      check("de", 32'(de), 32'(e2.de));
      check("hsync", 32'(hsync), 32'(e2.hs));
      check("vsync", 32'(vsync), 32'(e2.vs));
      check("pix_data", 32'(pix_data), 32'(e2.pix));
      check("frame_done", 32'(frame_done), 32'(e2.done));
      check("underflow", 32'(underflow), 32'(m_uf));
    end
  end

  logic [DW-1:0] basic_exp [8] = '{24'h000000, 24'h010101, 24'h020202, 24'h030303,
                                   24'h040404, 24'h050505, 24'h060606, 24'h070707};
`ifdef FRAME_SCANOUT_PATTERN_EN
  logic [DW-1:0] blank_exp [8] = '{24'h000000, 24'hffffff, 24'h000000, 24'hffffff,
                                   24'hffffff, 24'h000000, 24'hffffff, 24'h000000};
`else
  logic [DW-1:0] blank_exp [8] = '{default: 24'h000000};
`endif

  initial begin
    logic [DW-1:0] cap [8];
    logic [AW-1:0] addrs [8];
    int got, nrd, done_at, ndone, period, vw, hw, found;
    bit pv;

    for (int i = 0; i < 8; i++) mem[i] = DW'(i * 32'h010101);

    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 32'd1);
    check("rst_de", 32'(de), 32'd0);
    check("rst_pix", 32'(pix_data), 32'd0);
    reset = 1'b1;
    checking = 1;
    repeat (6) @(negedge clk);
    check("idle_de", 32'(de), 32'd0);

    // Basic scan from addr*0x010101
    frame_rdy = 1'b1; en = 1'b1;
    got = 0; nrd = 0; done_at = -1;
    for (int c = 0; c < 200 && got < 8; c++) begin
      @(negedge clk);
      if (rd_en == 1'b0 && nrd < 8) begin addrs[nrd] = rd_addr; nrd++; end
      if (de) begin
        cap[got] = pix_data;
        if (frame_done) done_at = got;
        got++;
      end
    end
    check("basic_pixels", 32'(got), 32'd8);
    check("basic_reads", 32'(nrd), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("basic_pix", 32'(cap[i]), 32'(basic_exp[i]));
      check("basic_addr", 32'(addrs[i]), 32'(i));
    end
    check("done_pixel", 32'(done_at), 32'd7);

    // Frame timing measured between vsync rising edges
    pv = vsync; found = 0;
    for (int c = 0; c < H_TOTAL * V_TOTAL * 3 && found == 0; c++) begin
      @(negedge clk);
      if (vsync && !pv) found = 1;
      pv = vsync;
    end
    period = 0; vw = 1; hw = hsync ? 1 : 0; found = 0;
    for (int c = 0; c < H_TOTAL * V_TOTAL * 3 && found == 0; c++) begin
      @(negedge clk);
      period++;
      if (vsync && !pv) found = 1;
      else begin
        if (vsync) vw++;
        if (hsync) hw++;
      end
      pv = vsync;
    end
    check("frame_period", 32'(period), 32'd40);
    check("vsync_width", 32'(vw), 32'd8);
    check("hsync_per_frame", 32'(hw), 32'd10);

    // Underflow: blank frame, then frame_rdy raised mid-frame
    frame_rdy = 1'b0;
    got = 0; nrd = 0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      @(negedge clk);
      if (rd_en == 1'b0) nrd++;
      if (de) begin
        cap[got] = pix_data;
        got++;
        if (got == 2) frame_rdy = 1'b1;
      end
    end
    check("blank_pixels", 32'(got), 32'd8);
    check("blank_reads", 32'(nrd), 32'd0);
    for (int i = 0; i < 8; i++) check("blank_pix", 32'(cap[i]), 32'(blank_exp[i]));
    check("underflow_set", 32'(underflow), 32'd1);
    repeat (50) @(negedge clk);
    check("underflow_sticky", 32'(underflow), 32'd1);

    // Stop: drop en during line 1 of a scanned frame
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (rd_en == 1'b0 && rd_addr == 3'd4) found = 1;
    end
    check("stop_found", 32'(found), 32'd1);
    en = 1'b0;
    got = 0; nrd = 0; ndone = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_en == 1'b0) nrd++;
      if (frame_done) ndone++;
      if (de) begin
        if (got < 8) cap[got] = pix_data;
        got++;
      end
    end
    check("stop_pixels", 32'(got), 32'd4);
    check("stop_reads", 32'(nrd), 32'd3);
    check("stop_done", 32'(ndone), 32'd1);
    for (int i = 0; i < 4; i++) check("stop_pix", 32'(cap[i]), 32'(basic_exp[i + 4]));

    // Restart begins at address 0
    en = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (rd_en == 1'b0) found = 1;
    end
    check("restart_read", 32'(found), 32'd1);
    check("restart_addr", 32'(rd_addr), 32'd0);

    // Asynchronous reset in the middle of active video
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (de) found = 1;
    end
    check("reset_found_de", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_rd_en", 32'(rd_en), 32'd1);
    check("arst_rd_addr", 32'(rd_addr), 32'd0);
    check("arst_pix", 32'(pix_data), 32'd0);
    check("arst_de", 32'(de), 32'd0);
    check("arst_hsync", 32'(hsync), 32'd0);
    check("arst_vsync", 32'(vsync), 32'd0);
    check("arst_done", 32'(frame_done), 32'd0);
    check("arst_underflow", 32'(underflow), 32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_de", 32'(de), 32'd0);
    check("post_rst_rd_en", 32'(rd_en), 32'd1);

    // Randomized run with random frame-buffer contents
    for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
    frame_rdy = 1'b1; en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) frame_rdy = ~frame_rdy;
    end

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
